// File: rtl/axis_dma_write_subsys_pkg.sv
// Shared defaults and FSM state encodings for the AXIS DMA write subsystem.
package axis_dma_write_subsys_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic {SRC_IDLE, SRC_SEND} src_state_e;
  typedef enum logic {WR_IDLE, WR_RUN} wr_state_e;
  typedef enum logic [1:0] {CHK_IDLE, CHK_READ, CHK_DRAIN} chk_state_e;

endpackage

// File: rtl/dma_wr_engine.sv
// Stream-to-memory writer: one registered write strobe per accepted beat.
//   state   | meaning
//   WR_IDLE | waiting for start
//   WR_RUN  | accepting beats until the remaining count reaches zero
module dma_wr_engine
  import axis_dma_write_subsys_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       length,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              done
);

  wr_state_e         state, state_nxt;
  logic [31:0]       rem;
  logic [ADDR_W-1:0] addr;
  logic              done_nxt;
  logic              hs;
  logic              launch;

  assign hs = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WR_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    done_nxt  = 1'b0;
    launch    = 1'b0;
    case (state)
      WR_IDLE: begin
        if (start) begin
          launch = 1'b1;
          // zero-length jobs finish straight from idle
          if (length == 32'd0) done_nxt = 1'b1;
          else                 state_nxt = WR_RUN;
        end
      end
      WR_RUN: begin
        s_ready = (rem != 32'd0);
        if (rem == 32'd0) begin
          done_nxt  = 1'b1;
          state_nxt = WR_IDLE;
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem          <= '0;
      addr         <= '0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      done         <= 1'b0;
    end else begin
      done         <= done_nxt;
      mem_wr_valid <= hs;
      if (launch) begin
        addr <= base_addr;
        rem  <= length;
      end else if (hs) begin
        mem_wr_addr <= addr;
        mem_wr_data <= s_data;
        addr        <= addr + 1'b1;
        rem         <= rem - 32'd1;
      end
    end
  end

endmodule

// File: rtl/axis_dma_write_subsys.sv
// Counting stream source -> DMA writer -> readback checker. Optional macro
// CHK_ERR_COUNT_EN adds a saturating mismatch counter output chk_err_count.
//   state     | meaning
//   SRC_IDLE  | source waiting for start_src
//   SRC_SEND  | source presenting beats 0..SRC_BEATS-1
//   CHK_IDLE  | checker waiting for start_chk
//   CHK_READ  | checker issuing one read per cycle
//   CHK_DRAIN | last read data being compared
module axis_dma_write_subsys
  import axis_dma_write_subsys_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SRC_BEATS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_src,
  input  logic              start_dma,
  input  logic              start_chk,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       length,
  output logic              src_done,
  output logic              dma_done,
  output logic              chk_done,
  output logic              chk_error,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef CHK_ERR_COUNT_EN
  ,
  output logic [15:0]       chk_err_count
`else
`endif
);

  src_state_e        src_state, src_state_nxt;
  logic [31:0]       src_rem;
  logic [DATA_W-1:0] src_data;
  logic              src_valid, src_ready, src_last, src_launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_state <= SRC_IDLE;
    else        src_state <= src_state_nxt;
  end

  always_comb begin
    src_state_nxt = src_state;
    src_valid     = 1'b0;
    src_last      = 1'b0;
    src_launch    = 1'b0;
    case (src_state)
      SRC_IDLE: if (start_src) begin
        src_launch    = 1'b1;
        src_state_nxt = SRC_SEND;
      end
      SRC_SEND: begin
        src_valid = 1'b1;
        src_last  = src_ready && (src_rem == 32'd1);
        if (src_last) src_state_nxt = SRC_IDLE;
      end
      default: src_state_nxt = SRC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_rem  <= '0;
      src_data <= '0;
      src_done <= 1'b0;
    end else begin
      src_done <= src_last;
      if (src_launch) begin
        src_rem  <= 32'(SRC_BEATS);
        src_data <= '0;
      end else if (src_valid && src_ready) begin
        src_rem  <= src_rem - 32'd1;
        src_data <= src_data + 1'b1;
      end
    end
  end

  dma_wr_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_dma),
    .base_addr    (base_addr),
    .length       (length),
    .s_valid      (src_valid),
    .s_data       (src_data),
    .s_ready      (src_ready),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .done         (dma_done)
  );

  chk_state_e        chk_state, chk_state_nxt;
  logic [31:0]       chk_rem;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp, cmp_exp;
  logic              cmp_valid, chk_mis, chk_launch, chk_done_nxt;

  assign mem_rd_addr = chk_addr;
  assign chk_mis     = cmp_valid && (mem_rd_data != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_state <= CHK_IDLE;
    else        chk_state <= chk_state_nxt;
  end

  always_comb begin
    chk_state_nxt = chk_state;
    mem_rd_valid  = 1'b0;
    chk_done_nxt  = 1'b0;
    chk_launch    = 1'b0;
    case (chk_state)
      CHK_IDLE: if (start_chk) begin
        chk_launch = 1'b1;
        if (length == 32'd0) chk_done_nxt  = 1'b1;
        else                 chk_state_nxt = CHK_READ;
      end
      CHK_READ: begin
        mem_rd_valid = 1'b1;
        if (chk_rem == 32'd1) chk_state_nxt = CHK_DRAIN;
      end
      CHK_DRAIN: begin
        chk_done_nxt  = 1'b1;
        chk_state_nxt = CHK_IDLE;
      end
      default: chk_state_nxt = CHK_IDLE;
    endcase
  end

  // read data lags the request by one cycle, so the expected value is staged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_rem   <= '0;
      chk_addr  <= '0;
      chk_exp   <= '0;
      cmp_exp   <= '0;
      cmp_valid <= 1'b0;
      chk_error <= 1'b0;
      chk_done  <= 1'b0;
    end else begin
      chk_done  <= chk_done_nxt;
      cmp_valid <= mem_rd_valid;
      if (chk_launch) begin
        chk_rem   <= length;
        chk_addr  <= base_addr;
        chk_exp   <= '0;
        chk_error <= 1'b0;
      end else begin
        if (chk_mis) chk_error <= 1'b1;
        if (mem_rd_valid) begin
          cmp_exp  <= chk_exp;
          chk_exp  <= chk_exp + 1'b1;
          chk_addr <= chk_addr + 1'b1;
          chk_rem  <= chk_rem - 32'd1;
        end
      end
    end
  end

`ifdef CHK_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  chk_err_count <= '0;
    else if (chk_launch)                         chk_err_count <= '0;
    else if (chk_mis && chk_err_count != 16'hFFFF) chk_err_count <= chk_err_count + 16'd1;
  end
`else
  // mismatch counter not built
`endif

endmodule

// File: tb/tb_axis_dma_write_subsys.sv
// Directed bench for axis_dma_write_subsys with a behavioural byte memory.
module tb_axis_dma_write_subsys;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_src = 1'b0, start_dma = 1'b0, start_chk = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] length = '0;
  logic        src_done, dma_done, chk_done, chk_error;
  logic        mem_wr_valid, mem_rd_valid;
  logic [31:0] mem_wr_addr, mem_rd_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data = '0;
`ifdef CHK_ERR_COUNT_EN
  logic [15:0] chk_err_count;
`endif

  axis_dma_write_subsys dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_src    (start_src),
    .start_dma    (start_dma),
    .start_chk    (start_chk),
    .base_addr    (base_addr),
    .length       (length),
    .src_done     (src_done),
    .dma_done     (dma_done),
    .chk_done     (chk_done),
    .chk_error    (chk_error),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data)
`ifdef CHK_ERR_COUNT_EN
    ,
    .chk_err_count(chk_err_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [0:1023];
  logic       poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [7:0] poke_data = '0;

  always @(posedge clk) begin
    if (mem_wr_valid) mem[mem_wr_addr[9:0]] <= mem_wr_data;
    if (poke_en)      mem[poke_addr] <= poke_data;
    if (mem_rd_valid) mem_rd_data <= mem[mem_rd_addr[9:0]];
  end

  int          wr_total = 0, rd_total = 0, src_cnt = 0, dma_cnt = 0, chk_cnt = 0;
  int          wr_mark = 0, rd_mark = 0;
  logic [31:0] run_base = '0, rd_base = '0;

  always @(negedge clk) begin
    if (mem_wr_valid) begin
      check("wr_addr", mem_wr_addr, 32'(run_base + 32'(wr_total - wr_mark)));
      check("wr_data", mem_wr_data, 8'(wr_total - wr_mark));
      wr_total++;
    end
    if (mem_rd_valid) begin
      check("rd_addr", mem_rd_addr, 32'(rd_base + 32'(rd_total - rd_mark)));
      rd_total++;
    end
    if (src_done) src_cnt++;
    if (dma_done) dma_cnt++;
    if (chk_done) chk_cnt++;
  end

  task automatic pulse(input int which);
    case (which)
      0: start_src = 1'b1;
      1: start_dma = 1'b1;
      default: start_chk = 1'b1;
    endcase
    @(negedge clk);
    start_src = 1'b0;
    start_dma = 1'b0;
    start_chk = 1'b0;
  endtask

  task automatic wait_pulse(input int which, input string tag);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      case (which)
        0: seen = src_done;
        1: seen = dma_done;
        default: seen = chk_done;
      endcase
    end
    check(tag, seen, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_write(input logic [31:0] base, input logic [31:0] len, input bit src_first);
    int s0 = src_cnt;
    base_addr = base;
    length    = len;
    run_base  = base;
    wr_mark   = wr_total;
    if (src_first) begin
      pulse(0);
      repeat (4) @(negedge clk);
      check("hold_valid", dut.src_valid, 1'b1);
      check("hold_beat0", dut.src_data, 8'h00);
      check("no_wr_before_dma", wr_total - wr_mark, 0);
      pulse(1);
    end else begin
      pulse(1);
      @(negedge clk);
      pulse(0);
    end
    wait_pulse(1, "dma_done_seen");
    check("wr_count", wr_total - wr_mark, len);
    check("src_done_count", src_cnt - s0, 1);
  endtask

  task automatic run_check(input logic [31:0] base, input logic [31:0] len, input bit exp_err);
    base_addr = base;
    length    = len;
    rd_base   = base;
    rd_mark   = rd_total;
    pulse(2);
    wait_pulse(2, "chk_done_seen");
    check("chk_error", chk_error, exp_err);
    check("rd_count", rd_total - rd_mark, len);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_flags", {src_done, dma_done, chk_done, chk_error, mem_wr_valid, mem_rd_valid}, 6'b0);
    check("rst_wr_addr", mem_wr_addr, 32'h0);
    check("rst_rd_addr", mem_rd_addr, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_write(32'h0, 32, 1'b0);
    run_check(32'h0, 32, 1'b0);

    run_write(32'h100, 32, 1'b0);
    run_check(32'h100, 32, 1'b0);

    poke_addr = 10'h105;
    poke_data = 8'hAA;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
    run_check(32'h100, 32, 1'b1);
`ifdef CHK_ERR_COUNT_EN
    check("err_count", chk_err_count, 16'd1);
`endif

    base_addr = 32'h40;
    length    = 0;
    wr_mark   = wr_total;
    rd_mark   = rd_total;
    pulse(1);
    check("len0_dma_done", dma_done, 1'b1);
    @(negedge clk);
    check("len0_dma_done_one_cycle", dma_done, 1'b0);
    pulse(2);
    check("len0_chk_done", chk_done, 1'b1);
    check("len0_chk_error_cleared", chk_error, 1'b0);
    @(negedge clk);
    check("len0_no_wr", wr_total - wr_mark, 0);
    check("len0_no_rd", rd_total - rd_mark, 0);

    run_write(32'h200, 32, 1'b1);
    run_check(32'h200, 32, 1'b0);

    run_write(32'hFFFF_FFF0, 32, 1'b0);
    run_check(32'hFFFF_FFF0, 32, 1'b0);

    base_addr = 32'h300;
    length    = 32;
    run_base  = 32'h300;
    wr_mark   = wr_total;
    pulse(1);
    @(negedge clk);
    pulse(0);
    n = 0;
    while ((wr_total - wr_mark) < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("beat10_reached", (wr_total - wr_mark) >= 10, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {src_done, dma_done, chk_done, chk_error, mem_wr_valid, mem_rd_valid}, 6'b0);
    check("midrst_wr_addr", mem_wr_addr, 32'h0);
    check("midrst_wr_data", mem_wr_data, 8'h0);
    check("midrst_rd_addr", mem_rd_addr, 32'h0);
    check("midrst_src_valid", dut.src_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    wr_mark = wr_total;
    rd_mark = rd_total;
    repeat (10) @(negedge clk);
    check("post_rst_no_wr", wr_total - wr_mark, 0);
    check("post_rst_no_rd", rd_total - rd_mark, 0);
    run_write(32'h300, 32, 1'b0);
    run_check(32'h300, 32, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
